// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment scanner (ss.hh) with frame-start snapshot and per-slot blanking.
// Optional build macro LEADING_ZERO_BLANK_EN blanks the leftmost digit when it is zero.
module seven_seg_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] du,
    input  logic [3:0] dd,
    input  logic [3:0] su,
    input  logic [3:0] sd,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int PC_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PC_W-1:0] PC_LAST  = PC_W'(SCAN_DIV - 1);
    localparam logic [PC_W-1:0] PC_BLANK = PC_W'(BLANK_CYC);

    logic [PC_W-1:0] pc;
    logic [1:0]      idx;
    logic [3:0]      snap_du, snap_dd, snap_su, snap_sd;

    logic [3:0] cur;
    logic       blank;
    logic [6:0] seg_nxt;
    logic [3:0] an_nxt;
    logic       dp_nxt;

    // Active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash.
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        cur = snap_du;
        case (idx)
            2'd0:    cur = snap_du;
            2'd1:    cur = snap_dd;
            2'd2:    cur = snap_su;
            default: cur = snap_sd;
        endcase

        blank = (pc < PC_BLANK);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx == 2'd3 && snap_sd == 4'd0)
            blank = 1'b1;
`endif

        an_nxt  = blank ? 4'b1111 : ~(4'b0001 << idx);
        seg_nxt = blank ? 7'h7F : decode(cur);
        dp_nxt  = blank || (idx != 2'd2);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc      <= '0;
            idx     <= 2'd0;
            snap_du <= 4'd0;
            snap_dd <= 4'd0;
            snap_su <= 4'd0;
            snap_sd <= 4'd0;
            an      <= 4'b1111;
            seg     <= 7'h7F;
            dp      <= 1'b1;
        end else begin
            if (pc == PC_LAST) begin
                pc  <= '0;
                idx <= idx + 2'd1;
            end else begin
                pc <= pc + PC_W'(1);
            end

            // Frame start falls inside blanking, so the load never tears a lit digit.
            if (pc == '0 && idx == 2'd0) begin
                snap_du <= du;
                snap_dd <= dd;
                snap_su <= su;
                snap_sd <= sd;
            end

            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: reference model pushes expected outputs per edge, monitor compares.
module tb_seven_seg_scan;

    localparam int SD = 4;
    localparam int BC = 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] du = 4'd3, dd = 4'd2, su = 4'd9, sd = 4'd5;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    always #5 clock = ~clock;

    seven_seg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clock(clock), .reset(reset),
        .du(du), .dd(dd), .su(su), .sd(sd),
        .seg(seg), .dp(dp), .an(an)
    );

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];
    int t = 0;
    logic [3:0] snap [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
    logic [6:0] font [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Reference: time since reset release gives slot and position; digits come from the frame-start sample.
    always @(posedge clock) begin
        int pc, idx;
        logic [3:0] d;
        logic [11:0] e;
        bit lit;
        if (reset) begin
            exp_q.push_back({4'b1111, 7'h7F, 1'b1});
            t = 0;
            snap = '{4'd0, 4'd0, 4'd0, 4'd0};
        end else begin
            pc  = t % SD;
            idx = (t / SD) % 4;
            d   = snap[idx];
            lit = (pc >= BC);
`ifdef LEADING_ZERO_BLANK_EN
            if (idx == 3 && snap[3] == 4'd0) lit = 0;
`endif
            if (lit)
                e = {4'b1111 & ~(4'(1) << idx), (d <= 9) ? font[d] : 7'b0111111, (idx == 2) ? 1'b0 : 1'b1};
            else
                e = {4'b1111, 7'h7F, 1'b1};
            exp_q.push_back(e);
            if (pc == 0 && idx == 0) snap = '{du, dd, su, sd};
            t++;
        end
    end

    always @(negedge clock) begin
        logic [11:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp} !== e) begin
                errors++;
                $display("FAIL scan_out t=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         t, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
        end
    end

    task automatic wait_pos(input int target);
        bit hit = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (t % 16 == target) begin
                hit = 1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_pos target=%0d not reached, t=%0d", target, t);
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        // Mid-frame change of su during idx1 must wait for the next frame.
        wait_pos(6);
        su = 4'd4;
        wait_pos(0);
        du = 4'd12;
        wait_pos(1);
        sd = 4'd0;
        repeat (40) @(negedge clock);
        // Reset mid-slot at idx2, pc2.
        wait_pos(10);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        for (int i = 0; i < 1500; i++) begin
            @(negedge clock);
            if ($urandom_range(7, 0) == 0) begin
                case ($urandom_range(3, 0))
                    0: du = 4'($urandom_range(15, 0));
                    1: dd = 4'($urandom_range(15, 0));
                    2: su = 4'($urandom_range(15, 0));
                    default: sd = ($urandom_range(2, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 0));
                endcase
            end
            if (reset) reset = 1'b0;
            else if ($urandom_range(199, 0) == 0) reset = 1'b1;
        end
        reset = 1'b0;
        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, clock cycles per digit slot; legal range is 4 or more.
REQ-002 The block SHALL have parameter BLANK_CYC, default 2, cycles at the start of each slot with all anodes off; legal range is 1 to SCAN_DIV-2.
REQ-003 The block SHALL have port clock, input, 1 bit, single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-005 The block SHALL have port du, input, 4 bits, BCD hundredths units.
REQ-006 The block SHALL have port dd, input, 4 bits, BCD hundredths tens.
REQ-007 The block SHALL have port su, input, 4 bits, BCD seconds units.
REQ-008 The block SHALL have port sd, input, 4 bits, BCD seconds tens.
REQ-009 The block SHALL have port seg, output, 7 bits, active-low segments, with seg[0]=a through seg[6]=g.
REQ-010 The block SHALL have port dp, output, 1 bit, active-low decimal point.
REQ-011 The block SHALL have port an, output, 4 bits, active-low digit enables, with an[0] for the rightmost digit.

Function
REQ-012 A prescaler pc SHALL count 0..SCAN_DIV-1 and wrap to 0; on wrap, digit index idx SHALL advance 0->1->2->3->0.
REQ-013 Snapshot registers SHALL load du, dd, su and sd in every cycle where pc==0 and idx==0; the display SHALL use only snapshot values, giving tear-free frames.
REQ-014 Slot mapping SHALL be: idx0=du/an[0], idx1=dd/an[1], idx2=su/an[2], idx3=sd/an[3].
REQ-015 seg, dp and an SHALL be registered; outputs in cycle n+1 are a function of pc, idx and snapshot in cycle n (one-cycle latency).
REQ-016 While pc<BLANK_CYC, an SHALL be 4'b1111, seg 7'h7F and dp 1; otherwise exactly one an bit, an[idx], SHALL be 0.
REQ-017 Decoding SHALL be standard active-low, {g..a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-018 Snapshot values 10..15 SHALL display a dash, seg=0111111.
REQ-019 dp SHALL be 0 only while idx==2 outside blanking, marking the seconds.hundredths separator; otherwise 1.
REQ-020 Input changes between snapshot points SHALL have no effect on outputs until the next frame start.

Reset
REQ-021 While reset=1: pc=0, idx=0, snapshots=0, an=4'b1111, seg=7'h7F, dp=1.
REQ-022 Reset asserted mid-slot SHALL take effect at the next clock edge, aborting the frame.
REQ-023 The first cycle after reset deassertion has pc==0 and idx==0, so the snapshot SHALL load in that cycle.

Configuration
REQ-024 With macro LEADING_ZERO_BLANK_EN defined, when snapshot sd==0 the idx3 slot SHALL keep an=4'b1111, seg=7'h7F and dp=1 for the whole slot.
REQ-025 Without LEADING_ZERO_BLANK_EN, all four digits SHALL always be shown, including a leading zero.
REQ-026 In both cases, timing of pc and idx SHALL be identical.

Verification (SCAN_DIV=4, BLANK_CYC=1)
REQ-027 Hold reset 3 cycles, then release -> an=1111, seg=7F and dp=1 during reset and in the first post-reset cycle.
REQ-028 Inputs du=3, dd=2, su=9, sd=5 -> slots show an=1110/seg=0110000, an=1101/seg=0100100, an=1011/seg=0010000 with dp=0, and an=0111/seg=0010010; each slot has 1 blank cycle followed by 3 lit cycles.
REQ-029 Change su from 9 to 4 while idx==1 -> idx2 still shows 9 in this frame and shows 4 (0011001) in the next frame.
REQ-030 Set du=12 -> idx0 slot seg=0111111.
REQ-031 Set sd=0: with LEADING_ZERO_BLANK_EN, the idx3 slot gives an=1111 for 4 cycles; without it, an=0111/seg=1000000.
REQ-032 Assert reset while idx==2 and pc==2 -> next cycle all outputs are at reset values; after release, scanning restarts at idx0.
